// File: rtl/pipeir_queue.sv
// IF/ID decoupling queue: a 2-entry FIFO of {pc4, ins} between fetch and decode.
// Optional ID-stall statistics counter when PIPEIR_STATS_EN is defined.
module pipeir_queue (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] pc4,
    input  logic [31:0] ins,
    input  logic        in_valid,
    input  logic        wir,
    input  logic        flush,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        d_valid,
`ifdef PIPEIR_STATS_EN
    output logic        in_ready,
    output logic [15:0] stall_cnt
`else
    output logic        in_ready
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] mem_pc4 [2];
    logic [31:0] mem_ins [2];
    logic        push;
    logic        pop;

    // Handshake status depends on registered state only, so IF sees no
    // combinational path from wir or flush.
    assign in_ready = (state_q != ST_FULL);
    assign d_valid  = (state_q != ST_EMPTY);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = d_valid & wir & ~flush;

    // Invalid head shows a NOP bubble rather than stale storage.
    assign dpc4 = d_valid ? mem_pc4[rd_ptr_q] : 32'h0;
    assign inst = d_valid ? mem_ins[rd_ptr_q] : 32'h0;

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!resetn) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (pop && !push) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default: begin
                    state_d  = ST_EMPTY;
                    rd_ptr_d = 1'b0;
                    wr_ptr_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; count decides which entries are meaningful.
        if (push) begin
            mem_pc4[wr_ptr_q] <= pc4;
            mem_ins[wr_ptr_q] <= ins;
        end
    end

`ifdef PIPEIR_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= 16'h0;
        end else if (d_valid && !wir && !flush && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pipeir_queue.md
PIPEIR_QUEUE -- requirements
Module: pipeir_queue

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, as listed below.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 pc4  input  32  PC+4 of the fetched instruction from the IF stage.
REQ-005 ins  input  32  fetched instruction word from the IF stage.
REQ-006 in_valid  input  1  pc4/ins hold a real fetched instruction this cycle.
REQ-007 wir  input  1  ID-stage accept: 1 = ID consumes the head entry this cycle, 0 = ID stalled.
REQ-008 flush  input  1  squash all queued and incoming instructions (taken branch/jump).
REQ-009 dpc4  output  32  PC+4 of the head entry, forwarded to ID.
REQ-010 inst  output  32  instruction of the head entry, forwarded to ID.
REQ-011 d_valid  output  1  head entry is valid.
REQ-012 in_ready  output  1  queue can accept a push this cycle; IF SHALL hold the PC when 0.
REQ-013 stall_cnt  output  16  ID-stall cycle count; present only when PIPEIR_STATS_EN is defined.

Function
REQ-014 Storage SHALL be a 2-entry FIFO of {pc4, ins} with 1-bit read and write pointers that wrap 1->0.
REQ-015 State SHALL be EMPTY (count 0), ONE (count 1) or FULL (count 2); the count is encoded in 2 bits.
REQ-016 in_ready SHALL be 1 when state != FULL and 0 when state == FULL (combinational, from state only).
REQ-017 push SHALL be in_valid & in_ready & ~flush; pop SHALL be d_valid & wir & ~flush.
REQ-018 On push only: write the entry at wr_ptr, advance wr_ptr, count +1 (EMPTY->ONE, ONE->FULL).
REQ-019 On pop only: advance rd_ptr, count -1 (FULL->ONE, ONE->EMPTY).
REQ-020 On push and pop in the same cycle (state ONE): count unchanged, both pointers advance, the new entry becomes head on the next cycle.
REQ-021 In state EMPTY, pop SHALL NOT occur even when wir=1, because d_valid=0.
REQ-022 in_valid=1 while FULL SHALL write nothing and leave all state unchanged.
REQ-023 flush SHALL take priority over push and pop: next cycle state EMPTY, both pointers 0, and the same-cycle input is dropped.
REQ-024 d_valid SHALL be 1 iff state != EMPTY.
REQ-025 dpc4/inst SHALL show the head entry when d_valid=1, and SHALL be 32'h0 (NOP bubble) when d_valid=0.
REQ-026 Latency SHALL be one cycle: an instruction pushed into EMPTY at edge N appears on inst after edge N.
REQ-027 Sustained throughput SHALL be one instruction per cycle while wir=1 and in_valid=1.
REQ-028 Entry data SHALL be written only on push; storage contents are don't-care when not referenced by count.

Reset
REQ-029 resetn=0 SHALL asynchronously force: state EMPTY, rd_ptr=0, wr_ptr=0, d_valid=0, inst=0, dpc4=0, in_ready=1, stall_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; the first edge after release SHALL behave as from EMPTY.
REQ-031 Storage array contents SHALL NOT need reset.

Configuration
REQ-032 Macro PIPEIR_STATS_EN defined: stall_cnt port exists; it increments by 1 on each cycle with d_valid=1 & wir=0 & flush=0, saturates at 16'hFFFF, and is cleared only by reset.
REQ-033 PIPEIR_STATS_EN undefined: the stall_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset then push ins=32'h8C010004, pc4=32'h4 with wir=1 -> next cycle inst=32'h8C010004, dpc4=32'h4, d_valid=1; a cycle later d_valid=0, inst=0.
REQ-035 wir=0 and three consecutive pushes A,B,C -> FULL after B, in_ready=0, C dropped; then wir=1 -> inst=A, then B, then d_valid=0.
REQ-036 ONE state holding A, push B with wir=1 -> next cycle inst=B, state ONE, in_ready=1.
REQ-037 FULL state, flush=1 together with in_valid=1 -> next cycle d_valid=0, inst=0, in_ready=1; the input is not queued.
REQ-038 Assert resetn=0 between edges while FULL -> d_valid=0 and in_ready=1 immediately, without a clock edge.
REQ-039 PIPEIR_STATS_EN defined, d_valid=1 and wir=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds; one flush cycle does not increment it.
